// File: rtl/spi_frame_deserializer.sv
// SPI peripheral-side frame deserializer: synchronises sclk/copi/n_cs into clk and
// assembles one {read_write, addr, data} frame per chip-select assertion.
// Ports: clk/rst_n (async active-low); sclk/copi/n_cs async SPI pins;
//   read_write/addr/data hold the last good frame; valid pulses one clk per new frame;
//   busy is high while shifting; frame_err pulses on an aborted frame.
// Optional feature macro: SPI_FRAME_ERR_EN enables the frame_err report (else tied 0).
module spi_frame_deserializer #(
  parameter int CDC_LEN = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              n_cs,
  output logic              read_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic SCLK_IDLE = (CPOL != 0);
  localparam logic RISE_SAMPLE = (CPOL == CPHA);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // sclk chain carries one extra history flop beyond the synchroniser for edge detection.
  logic [CDC_LEN:0]   sclk_sync;
  logic [CDC_LEN-1:0] copi_sync;
  logic [CDC_LEN-1:0] ncs_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {(CDC_LEN+1){SCLK_IDLE}};
      copi_sync <= '0;
      ncs_sync  <= '1;
    end else begin
      sclk_sync <= {sclk_sync[CDC_LEN-1:0], sclk};
      copi_sync <= {copi_sync[CDC_LEN-2:0], copi};
      ncs_sync  <= {ncs_sync[CDC_LEN-2:0], n_cs};
    end
  end

  logic sclk_now, sclk_prev, sample, copi_s, ncs_s;
  assign sclk_now  = sclk_sync[CDC_LEN-1];
  assign sclk_prev = sclk_sync[CDC_LEN];
  assign sample    = RISE_SAMPLE ? (sclk_now & ~sclk_prev) : (~sclk_now & sclk_prev);
  // copi tapped at the same depth as sclk_now so data and edge stay aligned.
  assign copi_s    = copi_sync[CDC_LEN-1];
  assign ncs_s     = ncs_sync[CDC_LEN-1];

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] frame_next;

  // Frame including the bit being sampled this cycle.
  assign frame_next = {shreg[FRAME_W-2:0], copi_s};

`ifdef SPI_FRAME_ERR_EN
  logic err_q;
  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      read_write <= 1'b0;
      addr       <= '0;
      data       <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          busy  <= 1'b0;
          cnt   <= '0;
          shreg <= '0;
          if (!ncs_s) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          // A chip-select rise outranks a coincident sample event.
          if (ncs_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
`ifdef SPI_FRAME_ERR_EN
            err_q <= (cnt != '0);
`endif
          end else if (sample) begin
            shreg <= frame_next;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
              read_write <= frame_next[FRAME_W-1];
              addr       <= frame_next[FRAME_W-2 -: ADDR_W];
              data       <= frame_next[DATA_W-1:0];
              valid      <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          // Extra sclk edges are ignored until chip-select is released.
          busy <= 1'b0;
          if (ncs_s) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_deserializer.sv
module tb_spi_frame_deserializer;

  localparam int H = 6;  // clk periods per SCLK half-period
`ifdef SPI_FRAME_ERR_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] sclk_p, copi_p, ncs_p;

  logic        rw0, valid0, busy0, err0;
  logic [6:0]  addr0;
  logic [7:0]  data0;
  logic        rw1, valid1, busy1, err1;
  logic [14:0] addr1;
  logic [15:0] data1;
  logic        rw2, valid2, busy2, err2;
  logic [14:0] addr2;
  logic [15:0] data2;

  int passed = 0;
  int total  = 0;
  int vcnt0 = 0, vcnt1 = 0, vcnt2 = 0, ecnt0 = 0;
  logic busy_at_valid0 = 1'b1;
  int v_base, e_base;

  always #5 clk = ~clk;

  spi_frame_deserializer dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_p[0]), .copi(copi_p[0]), .n_cs(ncs_p[0]),
    .read_write(rw0), .addr(addr0), .data(data0), .valid(valid0), .busy(busy0),
    .frame_err(err0));

  spi_frame_deserializer #(.ADDR_W(15), .DATA_W(16), .CPOL(1), .CPHA(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_p[1]), .copi(copi_p[1]), .n_cs(ncs_p[1]),
    .read_write(rw1), .addr(addr1), .data(data1), .valid(valid1), .busy(busy1),
    .frame_err(err1));

  spi_frame_deserializer #(.ADDR_W(15), .DATA_W(16), .CPOL(1), .CPHA(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_p[2]), .copi(copi_p[2]), .n_cs(ncs_p[2]),
    .read_write(rw2), .addr(addr2), .data(data2), .valid(valid2), .busy(busy2),
    .frame_err(err2));

  always @(posedge clk) begin
    if (valid0) begin
      vcnt0 = vcnt0 + 1;
      busy_at_valid0 = busy0;
    end
    if (err0)   ecnt0 = ecnt0 + 1;
    if (valid1) vcnt1 = vcnt1 + 1;
    if (valid2) vcnt2 = vcnt2 + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input int d, input logic cpol, input logic cpha,
                           input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        copi_p[d] = v[i];
        wait_clk(H);
        sclk_p[d] = ~cpol;
        wait_clk(H);
        sclk_p[d] = cpol;
      end else begin
        sclk_p[d] = ~cpol;
        copi_p[d] = v[i];
        wait_clk(H);
        sclk_p[d] = cpol;
        wait_clk(H);
      end
    end
  endtask

  task automatic begin_frame(input int d);
    ncs_p[d] = 1'b0;
    wait_clk(H + 2);
  endtask

  task automatic end_frame(input int d);
    wait_clk(H);
    ncs_p[d] = 1'b1;
    wait_clk(H + 2);
  endtask

  initial begin
    rst_n  = 1'b0;
    sclk_p = 3'b110;
    copi_p = 3'b000;
    ncs_p  = 3'b111;
    wait_clk(4);

    // Reset state
    check("reset_outputs0", {rw0, addr0, data0, valid0, busy0, err0}, 64'h0);
    check("reset_outputs1", {rw1, addr1, data1, valid1, busy1}, 64'h0);
    rst_n = 1'b1;
    wait_clk(H);

    // Basic frame 1_0101010_11001100
    begin_frame(0);
    send_bits(0, 1'b0, 1'b0, 64'hAACC, 16);
    end_frame(0);
    check("f1_valid_count", vcnt0, 1);
    check("f1_rw", rw0, 1);
    check("f1_addr", addr0, 7'h2A);
    check("f1_data", data0, 8'hCC);
    check("f1_busy_at_valid", busy_at_valid0, 0);

    // Aborted frame after 9 bits, then 0_0000011_00000001
    v_base = vcnt0;
    e_base = ecnt0;
    begin_frame(0);
    send_bits(0, 1'b0, 1'b0, 64'h1FF, 9);
    check("abort_busy_mid", busy0, 1);
    end_frame(0);
    check("abort_no_valid", vcnt0 - v_base, 0);
    check("abort_err_count", ecnt0 - e_base, ERR_EXP);
    check("abort_outputs_kept", {rw0, addr0, data0}, {1'b1, 7'h2A, 8'hCC});
    begin_frame(0);
    send_bits(0, 1'b0, 1'b0, 64'h0301, 16);
    end_frame(0);
    check("f2_valid_count", vcnt0 - v_base, 1);
    check("f2_frame", {rw0, addr0, data0}, {1'b0, 7'h03, 8'h01});

    // Full frame 1_0001111_01010101 plus 5 extra 1-bits before nCS rise
    v_base = vcnt0;
    e_base = ecnt0;
    begin_frame(0);
    send_bits(0, 1'b0, 1'b0, 64'h8F55, 16);
    send_bits(0, 1'b0, 1'b0, 64'h1F, 5);
    check("extra_busy_done", busy0, 0);
    end_frame(0);
    check("extra_valid_count", vcnt0 - v_base, 1);
    check("extra_frame", {rw0, addr0, data0}, {1'b1, 7'h0F, 8'h55});
    check("extra_no_err", ecnt0 - e_base, 0);

    // Reset after 10 bits, then 1_1111111_00001111
    begin_frame(0);
    send_bits(0, 1'b0, 1'b0, 64'h3FF, 10);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {rw0, addr0, data0, valid0, busy0, err0}, 64'h0);
    wait_clk(3);
    rst_n = 1'b1;
    end_frame(0);
    v_base = vcnt0;
    begin_frame(0);
    send_bits(0, 1'b0, 1'b0, 64'hFF0F, 16);
    end_frame(0);
    check("post_reset_valid", vcnt0 - v_base, 1);
    check("post_reset_frame", {rw0, addr0, data0}, {1'b1, 7'h7F, 8'h0F});

    // Reset with nCS low and SCLK toggling, released mid-burst
    v_base = vcnt0;
    begin_frame(0);
    send_bits(0, 1'b0, 1'b0, 64'hF, 4);
    rst_n = 1'b0;
    send_bits(0, 1'b0, 1'b0, 64'h5, 3);
    check("burst_reset_outputs", {rw0, addr0, data0, valid0, busy0}, 64'h0);
    rst_n = 1'b1;
    send_bits(0, 1'b0, 1'b0, 64'h1B, 5);
    check("burst_no_valid_low", vcnt0 - v_base, 0);
    end_frame(0);
    check("burst_no_valid_high", vcnt0 - v_base, 0);
    begin_frame(0);
    send_bits(0, 1'b0, 1'b0, 64'h5A3C, 16);
    end_frame(0);
    check("burst_fresh_valid", vcnt0 - v_base, 1);
    check("burst_fresh_frame", {rw0, addr0, data0}, {1'b0, 7'h5A, 8'h3C});

    // Wide build, CPOL=1 CPHA=1
    begin_frame(1);
    send_bits(1, 1'b1, 1'b1, {32'h0, 1'b0, 15'h1234, 16'hBEEF}, 32);
    end_frame(1);
    check("m3_valid_count", vcnt1, 1);
    check("m3_frame", {rw1, addr1, data1}, {1'b0, 15'h1234, 16'hBEEF});

    // Wide build, CPOL=1 CPHA=0
    begin_frame(2);
    send_bits(2, 1'b1, 1'b0, {32'h0, 1'b0, 15'h1234, 16'hBEEF}, 32);
    end_frame(2);
    check("m2_valid_count", vcnt2, 1);
    check("m2_frame", {rw2, addr2, data2}, {1'b0, 15'h1234, 16'hBEEF});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_frame_deserializer.md
# spi_frame_deserializer

Parametrised SPI peripheral-side deserializer: synchronises SCLK, COPI and nCS into the system clock domain and assembles one frame per chip-select assertion. A frame is one read/write bit, an ADDR_W-bit address and a DATA_W-bit data word. The block presents the completed frame atomically with a one-cycle `valid` pulse to the register-file front end. Relative to the first-generation deserializer, it adds:

- configurable widths and SPI mode;
- nCS-based resynchronisation;
- atomic output update;
- an optional framing-error report.

## Interface
Parameters:
- `CDC_LEN`, 2: synchroniser depth in flops; must be ≥2.
- `ADDR_W`, 7: address width; must be ≥1.
- `DATA_W`, 8: data width; must be ≥1.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: sample phase. The sample edge is rising when CPOL==CPHA, falling otherwise.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `copi` in 1: SPI data in, asynchronous.
- `n_cs` in 1: chip select, active low, asynchronous.
- `read_write` out 1: R/W bit of the last good frame.
- `addr` out ADDR_W: address of the last good frame.
- `data` out DATA_W: data of the last good frame.
- `valid` out 1: one-`clk` pulse when a new frame is presented.
- `busy` out 1: high while a frame is being shifted in.
- `frame_err` out 1: one-`clk` pulse on an aborted frame; tied 0 unless the macro is set.

## Operation
- `FRAME_W = 1 + ADDR_W + DATA_W`. Bit order is MSB-first: R/W, then `addr[ADDR_W-1:0]`, then `data[DATA_W-1:0]`.
- Synchronisation:
  - `sclk`, `copi` and `n_cs` each pass through a CDC_LEN-flop synchroniser.
  - `sclk` has one extra history flop for edge detection.
  - A sample event is a sample-direction transition between stage CDC_LEN-1 and stage CDC_LEN of the SCLK chain.
  - `copi` is taken from stage CDC_LEN-1 of its chain, so data and edge are equally delayed.
- Internal state: a FRAME_W-bit shift register plus a bit counter of width `$clog2(FRAME_W+1)`. Outputs change only on frame completion.
- FSM states:
  - IDLE: synchronised `n_cs` high; counter = 0; `busy` = 0. Go to SHIFT when synchronised `n_cs` goes low.
  - SHIFT: `busy` = 1. Each sample event shifts in `copi` and increments the counter.
    - When the counter reaches FRAME_W, load `read_write`/`addr`/`data` from the shift register (including the bit just sampled), pulse `valid`, and go to DONE.
    - If `n_cs` rises with counter <FRAME_W: discard the frame, leave outputs unchanged, pulse `frame_err` (macro only), go to IDLE.
    - If `n_cs` rises with counter == 0: go to IDLE silently, with no error.
  - DONE: `busy` = 0. Sample events are ignored (extra clocks never corrupt outputs or wrap). Go to IDLE when `n_cs` rises.
- Sample events in IDLE are ignored.
- If an `n_cs` rise and a sample event occur in the same cycle, the `n_cs` rise wins and the bit is dropped.
- Reset, including mid-frame, takes effect immediately:
  - `read_write` = 0, `addr` = 0, `data` = 0.
  - `valid` = 0, `busy` = 0, `frame_err` = 0.
  - FSM = IDLE; counter and shift register = 0.
  - Synchroniser flops reset to the idle levels: `sclk`=CPOL, `n_cs`=1, `copi`=0.

## Timing
- Input-to-event latency: a pin transition is seen by the FSM CDC_LEN+1 `clk` rising edges after it is first captured, with up to +1 cycle of metastability uncertainty.
- `valid` is high for exactly one cycle, the cycle after the final bit's sample event is detected. Outputs are stable from that cycle until the next `valid` or reset.
- `frame_err` is high for exactly one cycle, the cycle after the synchronised `n_cs` rise is detected.
- Minimum SCLK high time and low time are each ≥ CDC_LEN+2 `clk` periods each. Faster SCLK is unsupported.
- Minimum nCS-high time between frames is ≥ CDC_LEN+2 `clk` periods.

## Configuration
- `SPI_FRAME_ERR_EN`:
  - Defined: aborted frames (nCS rise with 0 < counter < FRAME_W) produce the `frame_err` pulse.
  - Undefined: `frame_err` is constant 0 and the error logic is absent.
  - Frame discard behaviour is identical in both cases.

## Test plan
- Reset, defaults (CPOL=0, CPHA=0, ADDR_W=7, DATA_W=8), send 16 bits 1_0101010_11001100 -> one `valid` pulse; `read_write`=1, `addr`=0x2A, `data`=0xCC; `busy` falls on the same cycle.
- Send 9 bits then raise nCS, then a full frame 0_0000011_00000001 -> no `valid` for the partial frame; `frame_err` pulses once when the macro is set and stays 0 when unset; the second frame gives `addr`=0x03, `data`=0x01.
- Full frame followed by 5 extra SCLK pulses carrying 1s before nCS rises -> exactly one `valid`; outputs unchanged after the extra pulses.
- CPOL=1, CPHA=1, ADDR_W=15, DATA_W=16, frame R/W=0, addr=0x1234, data=0xBEEF -> `valid`, `addr`=0x1234, `data`=0xBEEF; the same frame with CPHA=0 timing yields the correct bits in the CPHA=0 build.
- Assert `rst_n` low after 10 bits, release, send a full frame 1_1111111_00001111 -> during reset all outputs are 0; after release exactly one `valid`, with `addr`=0x7F, `data`=0x0F.
- Assert `rst_n` with nCS held low and SCLK toggling; release mid-burst -> no `valid` until nCS goes high and then a fresh complete frame is sent.
